control_unit: RTL and testbench
===============================

# control_unit

Sequencing controller directly upstream of the 4-bit register/bus datapath. It drives every datapath control input (`LD_*`, `sel_A`, `sel_B`, `E`) through a fixed five-step micro-sequence, T0, T1, T2, T3, OUT. One pass computes R1←R2 and R2←R1+R2 (mod 16), then copies AC to `outr`. The number of passes is set by a parameter, and a start/busy/done handshake and an iteration count are exposed to the surrounding system.

## Interface
- `N_ITER`, default 4: passes per run; legal range 1..(2^CNT_W − 1); 0 is illegal.
- `CNT_W`, default 4: width of the iteration counter.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: reset, asynchronous and active-high.
- `start`  in  1: begin a run; sampled only in IDLE.
- `stall`  in  1: freeze the sequence for this cycle.
- `abort`  in  1: synchronous abandon of a run.
- `LD_DR1`, `LD_DR2`, `LD_R1`, `LD_AC`, `LD_R2`, `LD_R3`  out  1 each: datapath load enables.
- `sel_A`  out  3: Bus 1 source: 000 R1, 001 R2, 010 R3, 011 AC, 100 outr.
- `sel_B`  out  1: Bus 2 drive (R2).
- `E`  out  1: output-transfer enable (outr←Bus 1).
- `busy`  out  1: high in T0..OUT.
- `done`  out  1: one-cycle pulse at end of a completed run.
- `iter_cnt`  out  CNT_W: passes completed in the current run.

## Operation
- FSM states: IDLE, T0, T1, T2, T3, OUT, DONE. Outputs are a Moore decode of the state register, gated by `stall` as described below.
- Outputs per state. Any control output not listed is 0, and `sel_A` is 000 unless stated.
  - T0: `sel_A`=000, `sel_B`=1, `LD_DR1`=`LD_DR2`=1 (DR1←R1, DR2←R2).
  - T1: `sel_A`=001, `LD_R1`=`LD_AC`=1 (AC←DR1+DR2, R1←R2).
  - T2: `sel_A`=011, `LD_R3`=1 (R3←AC).
  - T3: `sel_A`=010, `LD_R2`=1 (R2←R3).
  - OUT: `sel_A`=011, `E`=1 (outr←AC).
  - IDLE and DONE: all control outputs 0.
- Transitions:
  - IDLE→T0 when `start`=1. Otherwise stay in IDLE.
  - T0→T1→T2→T3→OUT, one state per cycle.
  - OUT: `iter_cnt` increments. If the new value equals N_ITER, go to DONE; otherwise go to T0.
  - DONE→IDLE unconditionally.
- `iter_cnt` clears to 0 on the IDLE→T0 transition. It holds its value through DONE and IDLE until the next start, so software can read the final count.
- `stall`=1 in T0..OUT:
  - The state and `iter_cnt` hold.
  - All `LD_*`, `sel_B` and `E` are forced to 0 combinationally for that cycle, so no datapath register changes.
  - `sel_A` keeps its state value.
- `stall` is ignored in IDLE and DONE.
- `abort`=1 in T0..OUT (stall or not): next state is IDLE. No `done` pulse; `iter_cnt` holds.
- `abort` has priority over `stall` and over normal advance. `abort` in IDLE or DONE has no effect.
- `start` while `busy` is ignored. `start` and `abort` together in IDLE: start wins.
- Datapath arithmetic is 4-bit and wraps mod 16. The controller does not observe datapath values.

## Timing
- Reset (async assert, any state): state=IDLE, `iter_cnt`=0, `done`=0, `busy`=0, all `LD_*`/`E`/`sel_B`=0, `sel_A`=000. The first valid transition happens on the first rising edge after deassertion.
- `start` high at edge k: T0 outputs are visible in cycle k+1.
- Each pass takes 5 cycles. A stall-free run takes 5·N_ITER cycles busy, plus 1 DONE cycle, plus a return to IDLE.
- `done` is high for exactly the single DONE cycle: edge k+5·N_ITER, with `start` at edge k.
- `start` can be accepted again in the IDLE cycle directly after DONE.
- Reset mid-run returns to IDLE at once. Datapath contents are not restored by this block.
- Each stall cycle lengthens the run by exactly one cycle.

## Test plan
- Reset mid-T2 (async, between edges):
  - Outputs go to 0 and `sel_A` to 000 immediately.
  - `busy`=0; `iter_cnt`=0.
- Single pass, N_ITER=1, `start` at edge 0:
  - Cycles 1–5 show T0..OUT encodings exactly as listed.
  - `iter_cnt`=1 after OUT.
  - `done`=1 in cycle 6 only; IDLE in cycle 7.
- Integrated with datapath, R1=R2=1 forced after reset, N_ITER=6:
  - `outr` after each OUT: 2, 3, 5, 8, 13, 5 (wrap).
  - Final R1=13, R2=5.
  - `done` at cycle 31.
- Stall held for 3 cycles during T1:
  - No `LD_*` asserted during the stall.
  - `done` arrives 3 cycles later than in the stall-free run.
  - Datapath results are identical to the stall-free run.
- `abort` in T3 of pass 2 (N_ITER=4):
  - IDLE next cycle; no `done` pulse.
  - `iter_cnt`=1; R2 not loaded.
- `start` pulsed while busy and again in DONE:
  - Both are ignored.
  - `start` in the following IDLE cycle begins a new run with `iter_cnt` cleared to 0.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: five-step sequencer (T0..T3, OUT) for the 4-bit register/bus
// datapath. Each pass performs R1<-R2, R2<-R1+R2, outr<-AC, and a run
// repeats the pass N_ITER times behind a start/busy/done handshake.
module control_unit #(
  parameter int unsigned N_ITER = 4,
  parameter int unsigned CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  input  logic             abort,
  output logic             LD_DR1,
  output logic             LD_DR2,
  output logic             LD_R1,
  output logic             LD_AC,
  output logic             LD_R2,
  output logic             LD_R3,
  output logic [2:0]       sel_A,
  output logic             sel_B,
  output logic             E,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter_cnt
);

  localparam int unsigned SEL_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_OUT,
    S_DONE
  } state_e;

  typedef struct packed {
    logic             ld_dr1;
    logic             ld_dr2;
    logic             ld_r1;
    logic             ld_ac;
    logic             ld_r2;
    logic             ld_r3;
    logic             sel_b;
    logic             e;
    logic [SEL_W-1:0] sel_a;
    logic             busy;
    logic             done;
  } ctrl_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_q;

  // Moore control word for a given state.
  function automatic ctrl_t decode(input state_e s);
    ctrl_t c;
    c = '0;
    unique case (s)
      S_T0: begin
        c.sel_b  = 1'b1;
        c.ld_dr1 = 1'b1;
        c.ld_dr2 = 1'b1;
        c.busy   = 1'b1;
      end
      S_T1: begin
        c.sel_a = SEL_W'(1);
        c.ld_r1 = 1'b1;
        c.ld_ac = 1'b1;
        c.busy  = 1'b1;
      end
      S_T2: begin
        c.sel_a = SEL_W'(3);
        c.ld_r3 = 1'b1;
        c.busy  = 1'b1;
      end
      S_T3: begin
        c.sel_a = SEL_W'(2);
        c.ld_r2 = 1'b1;
        c.busy  = 1'b1;
      end
      S_OUT: begin
        c.sel_a = SEL_W'(3);
        c.e     = 1'b1;
        c.busy  = 1'b1;
      end
      S_DONE: c.done = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next state and iteration count; abort beats stall beats advance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_T0;
          cnt_d   = '0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (!stall) begin
          unique case (state_q)
            S_T0: state_d = S_T1;
            S_T1: state_d = S_T2;
            S_T2: state_d = S_T3;
            S_T3: state_d = S_OUT;
            default: begin
              cnt_d   = cnt_q + CNT_W'(1);
              state_d = (cnt_d == CNT_W'(N_ITER)) ? S_DONE : S_T0;
            end
          endcase
        end
      end
    endcase
  end

  // State, count and the registered control word decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= decode(state_d);
    end
  end

  // Stall suppresses every load/drive for the cycle; sel_A keeps the step value.
  assign LD_DR1   = ctrl_q.ld_dr1 & ~stall;
  assign LD_DR2   = ctrl_q.ld_dr2 & ~stall;
  assign LD_R1    = ctrl_q.ld_r1  & ~stall;
  assign LD_AC    = ctrl_q.ld_ac  & ~stall;
  assign LD_R2    = ctrl_q.ld_r2  & ~stall;
  assign LD_R3    = ctrl_q.ld_r3  & ~stall;
  assign sel_B    = ctrl_q.sel_b  & ~stall;
  assign E        = ctrl_q.e      & ~stall;
  assign sel_A    = ctrl_q.sel_a;
  assign busy     = ctrl_q.busy;
  assign done     = ctrl_q.done;
  assign iter_cnt = cnt_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed reset/single-pass/datapath checks and
// randomized start/stall/abort traffic against a step-counting model.
module tb_control_unit;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, stall = 1'b0, abort = 1'b0;
  logic start1 = 1'b0, stall1 = 1'b0, abort1 = 1'b0;

  logic LD_DR1, LD_DR2, LD_R1, LD_AC, LD_R2, LD_R3, sel_B, E, busy, done;
  logic [2:0] sel_A;
  logic [3:0] iter_cnt;

  logic o_dr1, o_dr2, o_r1, o_ac, o_r2, o_r3, o_selb, o_e, o_busy, o_done;
  logic [2:0] o_sela;
  logic [3:0] o_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: idle / stepping through 5-step passes / done pulse.
  bit m_busy = 0, m_done = 0;
  int m_phase = 0, m_cnt = 0;

  // Bench-side datapath driven by the main DUT's controls.
  logic dp_seed = 1'b0;
  logic [3:0] r1 = '0, r2 = '0, r3 = '0, ac = '0, dr1 = '0, dr2 = '0, outr = '0;
  logic [3:0] bus1;

  always #5 clk = ~clk;

  control_unit #(.N_ITER(N), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .abort(abort),
    .LD_DR1(LD_DR1), .LD_DR2(LD_DR2), .LD_R1(LD_R1), .LD_AC(LD_AC),
    .LD_R2(LD_R2), .LD_R3(LD_R3), .sel_A(sel_A), .sel_B(sel_B), .E(E),
    .busy(busy), .done(done), .iter_cnt(iter_cnt)
  );

  control_unit #(.N_ITER(1), .CNT_W(4)) u_one (
    .clk(clk), .rst(rst), .start(start1), .stall(stall1), .abort(abort1),
    .LD_DR1(o_dr1), .LD_DR2(o_dr2), .LD_R1(o_r1), .LD_AC(o_ac),
    .LD_R2(o_r2), .LD_R3(o_r3), .sel_A(o_sela), .sel_B(o_selb), .E(o_e),
    .busy(o_busy), .done(o_done), .iter_cnt(o_cnt)
  );

  always_comb begin
    case (sel_A)
      3'b000:  bus1 = r1;
      3'b001:  bus1 = r2;
      3'b010:  bus1 = r3;
      3'b011:  bus1 = ac;
      3'b100:  bus1 = outr;
      default: bus1 = 4'd0;
    endcase
  end

  always @(posedge clk) begin
    if (dp_seed) begin
      r1 <= 4'd1;
      r2 <= 4'd1;
    end else begin
      if (LD_DR1) dr1 <= bus1;
      if (LD_DR2) dr2 <= sel_B ? r2 : 4'd0;
      if (LD_AC)  ac  <= dr1 + dr2;
      if (LD_R1)  r1  <= bus1;
      if (LD_R2)  r2  <= bus1;
      if (LD_R3)  r3  <= bus1;
      if (E)      outr <= bus1;
    end
  end

  // Expected {LD_DR1,LD_DR2,LD_R1,LD_AC,LD_R2,LD_R3,sel_B,E,sel_A,busy,done}.
  function automatic logic [12:0] exp_vec(bit b, int ph, bit sl, bit d);
    logic [5:0] ld;
    logic sb, e;
    logic [2:0] sa;
    ld = '0; sb = 1'b0; e = 1'b0; sa = 3'b000;
    if (b) begin
      case (ph)
        0: begin ld = 6'b110000; sb = 1'b1; end
        1: begin ld = 6'b001100; sa = 3'b001; end
        2: begin ld = 6'b000001; sa = 3'b011; end
        3: begin ld = 6'b000010; sa = 3'b010; end
        default: begin e = 1'b1; sa = 3'b011; end
      endcase
    end
    if (sl) begin ld = '0; sb = 1'b0; e = 1'b0; end
    return {ld, sb, e, sa, b, d};
  endfunction

  function automatic logic [12:0] obs_main();
    return {LD_DR1, LD_DR2, LD_R1, LD_AC, LD_R2, LD_R3, sel_B, E, sel_A, busy, done};
  endfunction

  function automatic logic [12:0] obs_one();
    return {o_dr1, o_dr2, o_r1, o_ac, o_r2, o_r3, o_selb, o_e, o_sela, o_busy, o_done};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One main-DUT cycle: drive at negedge, check, then advance the model at posedge.
  task automatic cycle(input bit st, input bit sl, input bit ab, output bit e_seen);
    @(negedge clk);
    start = st; stall = sl; abort = ab;
    #1;
    chk("ctrl", 16'(obs_main()), 16'(exp_vec(m_busy, m_phase, sl, m_done)));
    chk("iter_cnt", 16'(iter_cnt), 16'(m_cnt));
    e_seen = E;
    @(posedge clk);
    if (m_done) begin
      m_done = 0;
    end else if (!m_busy) begin
      if (st) begin m_busy = 1; m_phase = 0; m_cnt = 0; end
    end else if (ab) begin
      m_busy = 0;
    end else if (!sl) begin
      if (m_phase == 4) begin
        m_cnt++;
        if (m_cnt == N) begin m_busy = 0; m_done = 1; end
        else m_phase = 0;
      end else begin
        m_phase++;
      end
    end
  endtask

  initial begin
    bit e;
    int a, b, s, runs, passes;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", 16'(obs_main()), 16'd0);
    chk("reset_cnt", 16'(iter_cnt), 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single-pass instance: T0..OUT in cycles 1-5, done in 6, idle in 7.
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      #1;
      chk($sformatf("one_ctrl_c%0d", j), 16'(obs_one()),
          16'(exp_vec(j <= 5, j - 1, 1'b0, j == 6)));
      chk($sformatf("one_cnt_c%0d", j), 16'(o_cnt), (j >= 6) ? 16'd1 : 16'd0);
      @(negedge clk);
    end

    // Async reset while in T2.
    cycle(1, 0, 0, e);
    cycle(0, 0, 0, e);
    cycle(0, 0, 0, e);
    #2 rst = 1'b1;
    #1;
    chk("rst_t2_ctrl", 16'(obs_main()), 16'd0);
    chk("rst_t2_cnt", 16'(iter_cnt), 16'd0);
    m_busy = 0; m_done = 0; m_cnt = 0; m_phase = 0;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Two back-to-back runs on seeded datapath with random stalls: Fibonacci mod 16.
    dp_seed = 1'b1;
    @(posedge clk);
    #1 dp_seed = 1'b0;
    a = 1; b = 1; runs = 0; passes = 0;
    for (int i = 0; i < 120; i++) begin
      bit st, sl;
      st = !m_busy && !m_done && runs < 2;
      if (st) runs++;
      sl = m_busy && ($urandom_range(0, 3) == 0);
      cycle(st, sl, 0, e);
      if (e) begin
        #1;
        s = (a + b) % 16;
        a = b;
        b = s;
        passes++;
        chk($sformatf("outr_p%0d", passes), 16'(outr), 16'(s));
      end
    end
    chk("passes", 16'(passes), 16'(2 * N));
    chk("final_r1", 16'(r1), 16'(a));
    chk("final_r2", 16'(r2), 16'(b));

    // Abort in T3 of pass 2.
    cycle(1, 0, 0, e);
    repeat (8) cycle(0, 0, 0, e);
    cycle(0, 0, 1, e);
    cycle(0, 0, 0, e);
    cycle(0, 0, 0, e);

    // Random start/stall/abort traffic.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 19) == 0, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
